result_display: RTL and testbench

//  Back end of the calculator datapath. Converts an 11-bit two's-complement result

---
 rtl/calc_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 31 +++
 rtl/result_display.sv | 152 +++++++++++++++
 tb/tb_result_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: digit codes for the display back end,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and datapath defaults.
package calc_pkg;

    localparam int DATA_W_DEF  = 11;
    localparam int MAX_MAG_DEF = 999;

    // Non-numeric digit codes stored in the display registers
    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] DIG_MINUS = 4'hB;
    localparam logic [3:0] DIG_E     = 4'hC;
    localparam logic [3:0] DIG_R     = 4'hD;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_UPDATE = 2'd3
    } disp_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low 7-segment decoder.
// Codes 0-9 are numerals; BLANK/MINUS/E/r come from calc_pkg; 4'hE/4'hF are dark.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Map one stored digit code to its segment pattern
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0:      o_seg = SEG_0;
            4'h1:      o_seg = SEG_1;
            4'h2:      o_seg = SEG_2;
            4'h3:      o_seg = SEG_3;
            4'h4:      o_seg = SEG_4;
            4'h5:      o_seg = SEG_5;
            4'h6:      o_seg = SEG_6;
            4'h7:      o_seg = SEG_7;
            4'h8:      o_seg = SEG_8;
            4'h9:      o_seg = SEG_9;
            DIG_MINUS: o_seg = SEG_MINUS;
            DIG_E:     o_seg = SEG_E;
            DIG_R:     o_seg = SEG_R;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Calculator result back end: signed result -> sign + 3 BCD digits (double-dabble,
// one bit per cycle), shown on a 4-digit multiplexed active-low 7-segment display.
// Magnitudes above MAX_MAG or an upstream overflow show "Err".
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module result_display
    import calc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_MAG     = MAX_MAG_DEF,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              ovf_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        an,
    output logic [6:0]        seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    disp_state_t              r_state;
    logic signed [DATA_W-1:0] r_value;
    logic                     r_ovf;
    logic                     r_neg;
    logic                     r_zero;
    logic                     r_bad;
    logic [DATA_W-1:0]        r_mag;
    logic [11:0]              r_bcd;
    logic [4:0]               r_step;
    logic [15:0]              r_disp;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic [CNT_W-1:0]         r_cnt;
    logic [1:0]               r_idx;

    logic [DATA_W-1:0]        w_mag;
    logic                     w_too_big;
    logic [11:0]              w_bcd_adj;
    logic [15:0]              w_disp_next;
    logic [3:0]               w_code;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int n = 0; n < 3; n++) begin
            if (b[n*4 +: 4] >= 4'd5)
                r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // -1024 negates to itself, which read unsigned is the correct magnitude 1024
    assign w_mag     = r_value[DATA_W-1] ? $unsigned(-r_value) : $unsigned(r_value);
    assign w_too_big = ({{(32-DATA_W){1'b0}}, w_mag} > 32'(MAX_MAG));
    assign w_bcd_adj = dabble_adj(r_bcd);

    // Assemble the four digit codes the UPDATE state will commit
    always_comb begin
        w_disp_next = {DIG_BLANK, DIG_E, DIG_R, DIG_R};
        if (!r_bad) begin
            w_disp_next[15:12] = (r_neg && !r_zero) ? DIG_MINUS : DIG_BLANK;
            w_disp_next[11:0]  = r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
            if (r_bcd[11:8] == 4'd0) begin
                w_disp_next[11:8] = DIG_BLANK;
                if (r_bcd[7:4] == 4'd0)
                    w_disp_next[7:4] = DIG_BLANK;
            end
`endif
        end
    end

    // Conversion FSM; display registers change only in UPDATE so they are never half-written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_disp  <= {4{DIG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_value <= value;
                        r_ovf   <= ovf_in;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_neg   <= r_value[DATA_W-1];
                    r_mag   <= w_mag;
                    r_zero  <= (w_mag == '0);
                    r_bad   <= r_ovf | w_too_big;
                    r_bcd   <= '0;
                    r_step  <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd  <= {w_bcd_adj[10:0], r_mag[DATA_W-1]};
                    r_mag  <= r_mag << 1;
                    r_step <= r_step + 5'd1;
                    if (r_step == 5'(DATA_W-1))
                        r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_disp  <= w_disp_next;
                    r_done  <= 1'b1;
                    r_err   <= r_bad;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Free-running refresh divider; each wrap moves the scan to the next digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_W'(REFRESH_DIV-1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_code = r_disp[{r_idx, 2'b00} +: 4];

    seg7_decode u_dec (
        .i_code (w_code),
        .o_seg  (seg)
    );

    assign an   = ~(4'b0001 << r_idx);
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: reset state, scan order, directed vector table,
// randomized values against an arithmetic reference model, and multi-cycle
// corner sequences (start while busy, reset mid-conversion).
module tb_result_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] value;
    logic        ovf_in;
    logic        busy, done, err;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_display #(.DATA_W(11), .MAX_MAG(999), .REFRESH_DIV(RD)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .ovf_in (ovf_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .an     (an),
        .seg    (seg)
    );

    typedef struct {
        logic [10:0] v;
        logic        o;
        logic [15:0] exp_disp;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Segment pattern expected for a digit code, built from lit segments (gfedcba)
    function automatic logic [6:0] seg_of(input int code);
        logic [6:0] lit;
        case (code)
            0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
            4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
            8: lit = 7'h7F;  9: lit = 7'h6F;
            11: lit = 7'h40;                 // minus: g only
            12: lit = 7'h79;                 // E: a,d,e,f,g
            13: lit = 7'h50;                 // r: e,g
            default: lit = 7'h00;            // blank
        endcase
        return ~lit;
    endfunction

    function automatic logic [3:0] code_of(input logic [6:0] s);
        for (int c = 0; c < 14; c++) begin
            if (c != 10 && seg_of(c) == s) return 4'(c);
        end
        if (s == 7'h7F) return 4'hA;
        return 4'hF;
    endfunction

    // Reference model: what the four display positions should read for a result
    function automatic logic [15:0] model_disp(input logic [10:0] v, input logic o);
        int s, mag, h, t, u;
        logic [3:0] d3, d2, d1, d0;
        s   = $signed(v);
        mag = (s < 0) ? -s : s;
        if (o || mag > 999) return 16'hACDD;
        h  = mag / 100;
        t  = (mag / 10) % 10;
        u  = mag % 10;
        d3 = (s < 0 && mag != 0) ? 4'hB : 4'hA;
        d2 = 4'(h);
        d1 = 4'(t);
        d0 = 4'(u);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) begin
            d2 = 4'hA;
            if (t == 0) d1 = 4'hA;
        end
`endif
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic model_err(input logic [10:0] v, input logic o);
        int s, mag;
        s   = $signed(v);
        mag = (s < 0) ? -s : s;
        return o || (mag > 999);
    endfunction

    // Observe the multiplexed display and recover the code shown in each position
    task automatic read_disp(input string name, output logic [15:0] codes);
        bit found;
        codes = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int t = 0; t < 8 * RD + 4 && !found; t++) begin
                @(negedge clk);
                if (an == 4'(~(4'b0001 << k))) begin
                    codes[k*4 +: 4] = code_of(seg);
                    found = 1;
                end
            end
            if (!found) check({name, "_scan_timeout"}, 32'(an), 32'(~(4'b0001 << k)));
        end
    endtask

    // One conversion; optional second start at +s2_at and reset at +rst_at (0 = none)
    task automatic do_conv(input logic [10:0] v, input logic o, input int s2_at,
                           input logic [10:0] v2, input int rst_at,
                           output int n_done, output int lat, output logic busy_mid);
        @(posedge clk); #1;
        value = v; ovf_in = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; lat = -1; busy_mid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == s2_at);
            if (k == s2_at) begin value = v2; ovf_in = 1'b0; end
            rst = (k == rst_at);
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) lat = k;
            end
            if (k == 5) busy_mid = busy;
        end
        start = 1'b0; rst = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [15:0] got;
    int          nd, lat;
    logic        bm;
    logic [3:0]  prev_an;
    int          steps;

    initial begin
        rst = 1'b1; start = 1'b0; value = '0; ovf_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_an",   32'(an),   32'hE);
        check("rst_seg",  32'(seg),  32'h7F);
        rst = 1'b0;

        // Scan order: exactly one enable low, rotating 0,1,2,3,0...
        prev_an = an;
        steps = 0;
        for (int c = 0; c < 10 * RD; c++) begin
            @(negedge clk);
            if (an != prev_an) begin
                check("scan_order", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                steps++;
                prev_an = an;
            end
        end
        check("scan_steps", 32'(steps >= 8), 32'd1);

        // Directed vectors
        vecs.push_back('{11'd123,  1'b0, 16'hA123, 1'b0});
`ifdef LEADING_ZERO_BLANK_EN
        vecs.push_back('{11'h7F9,  1'b0, 16'hBAA7, 1'b0});
        vecs.push_back('{11'd0,    1'b0, 16'hAAA0, 1'b0});
        vecs.push_back('{11'd40,   1'b0, 16'hAA40, 1'b0});
`else
        vecs.push_back('{11'h7F9,  1'b0, 16'hB007, 1'b0});
        vecs.push_back('{11'd0,    1'b0, 16'hA000, 1'b0});
        vecs.push_back('{11'd40,   1'b0, 16'hA040, 1'b0});
`endif
        vecs.push_back('{11'd1000, 1'b0, 16'hACDD, 1'b1});
        vecs.push_back('{11'h400,  1'b0, 16'hACDD, 1'b1});
        vecs.push_back('{11'd5,    1'b1, 16'hACDD, 1'b1});
        vecs.push_back('{11'h419,  1'b0, 16'hB999, 1'b0});
        vecs.push_back('{11'd999,  1'b0, 16'hA999, 1'b0});
        vecs.push_back('{11'd305,  1'b0, 16'hA305, 1'b0});
        foreach (vecs[i]) begin
            do_conv(vecs[i].v, vecs[i].o, 0, '0, 0, nd, lat, bm);
            check("vec_latency", 32'(lat), 32'd13);
            check("vec_ndone",   32'(nd),  32'd1);
            check("vec_busy_mid", 32'(bm), 32'd1);
            check("vec_busy_end", 32'(busy), 32'd0);
            check("vec_err",     32'(err), 32'(vecs[i].exp_err));
            read_disp("vec", got);
            check("vec_disp",    32'(got), 32'(vecs[i].exp_disp));
        end

        // Randomized values against the model
        for (int i = 0; i < 30; i++) begin
            logic [10:0] rv;
            logic        ro;
            int          r;
            if (i % 2 == 1) begin
                r  = int'($urandom_range(0, 1998)) - 999;
                rv = r[10:0];
            end else begin
                rv = 11'($urandom_range(0, 2047));
            end
            ro = ($urandom_range(0, 7) == 0);
            do_conv(rv, ro, 0, '0, 0, nd, lat, bm);
            check("rnd_latency", 32'(lat), 32'd13);
            check("rnd_err",     32'(err), 32'(model_err(rv, ro)));
            read_disp("rnd", got);
            check("rnd_disp",    32'(got), 32'(model_disp(rv, ro)));
        end

        // Start while busy is ignored: one done, first value shown
        do_conv(11'd123, 1'b0, 5, 11'h419, 0, nd, lat, bm);
        check("busy_start_ndone", 32'(nd),  32'd1);
        check("busy_start_lat",   32'(lat), 32'd13);
        check("busy_start_err",   32'(err), 32'd0);
        read_disp("busy_start", got);
        check("busy_start_disp",  32'(got), 32'hA123);

        // Reset mid-conversion: no done, not busy, display dark
        do_conv(11'd1000, 1'b0, 0, '0, 6, nd, lat, bm);
        check("rst_mid_ndone", 32'(nd),   32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_err",   32'(err),  32'd0);
        read_disp("rst_mid", got);
        check("rst_mid_disp",  32'(got),  32'hAAAA);

        // Next conversion after the abort behaves normally
        do_conv(11'd456, 1'b0, 0, '0, 0, nd, lat, bm);
        check("post_rst_lat",  32'(lat), 32'd13);
        read_disp("post_rst", got);
        check("post_rst_disp", 32'(got), 32'hA456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
